// File: rtl/timer_pkg.sv
// Shared types, command codes and next-state function for the timer control stage.
package timer_pkg;

  localparam int unsigned CNT_W_DEFAULT = 4;

  localparam logic [1:0] CTRL_HOLD  = 2'b00;
  localparam logic [1:0] CTRL_CLEAR = 2'b01;
  localparam logic [1:0] CTRL_COUNT = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    CLEAR   = 3'b001,
    RUN     = 3'b010,
    PAUSE   = 3'b011,
    EXPIRED = 3'b100
  } state_t;

  // Transition table; a hit in RUN outranks both buttons, start outranks stop.
  function automatic state_t next_state(state_t cur, logic start_e, logic stop_e, logic hit);
    state_t nxt;
    nxt = cur;
    case (cur)
      IDLE:    if (start_e) nxt = CLEAR;
      CLEAR:   nxt = RUN;
      RUN: begin
        if (hit)          nxt = EXPIRED;
        else if (start_e) nxt = CLEAR;
        else if (stop_e)  nxt = PAUSE;
      end
      PAUSE: begin
        if (start_e)     nxt = CLEAR;
        else if (stop_e) nxt = RUN;
      end
      EXPIRED: begin
        if (start_e)     nxt = CLEAR;
        else if (stop_e) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] ctrl_of(state_t st);
    logic [1:0] c;
    c = CTRL_HOLD;
    case (st)
      CLEAR:   c = CTRL_CLEAR;
      RUN:     c = CTRL_COUNT;
      default: c = CTRL_HOLD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Push-button synchronizer followed by a rising-edge detector.
module btn_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign edge_out = w_synced & ~r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
      r_prev <= w_synced;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Turns start/stop buttons into timer commands and flags expiry against a
// programmable limit.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned LIMIT_RESET = 15,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_btn,
  input  logic             stop_btn,
  input  logic [CNT_W-1:0] limit_in,
  input  logic             limit_load,
  input  logic [CNT_W-1:0] tmout_in,
  output logic [1:0]       ctrl,
  output logic             running,
  output logic             expired,
  output logic             done_pulse,
  output logic [2:0]       state_out
);

  logic             w_start_edge;
  logic             w_stop_edge;
  logic             w_hit;
  state_t           w_state_nxt;
  state_t           r_state;
  logic [CNT_W-1:0] r_limit;

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start_edge (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (start_btn),
    .edge_out (w_start_edge)
  );

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stop_edge (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (stop_btn),
    .edge_out (w_stop_edge)
  );

  // A zero limit means free-run: the count may wrap and never expires.
  assign w_hit       = (r_limit != '0) && (tmout_in >= r_limit);
  assign w_state_nxt = next_state(r_state, w_start_edge, w_stop_edge, w_hit);
  assign state_out   = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_limit <= CNT_W'(LIMIT_RESET);
    end else if (limit_load) begin
      r_limit <= limit_in;
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      ctrl       <= CTRL_HOLD;
      running    <= 1'b0;
      expired    <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      ctrl       <= ctrl_of(w_state_nxt);
      running    <= (w_state_nxt == RUN);
      expired    <= (w_state_nxt == EXPIRED);
      done_pulse <= (w_state_nxt == EXPIRED) && (r_state != EXPIRED);
    end
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Control stage directly upstream of the seconds timer. It turns raw start/stop push-buttons into the timer's 2-bit ctrl command and watches the timer's 4-bit tmout count against a programmable limit. It also reports run/expired status and a one-cycle done pulse to the rest of the design.

Parameters:
CNT_W, 4, width of tmout_in, limit_in and the internal limit register
LIMIT_RESET, 15, value loaded into the limit register on reset
SYNC_STAGES, 2, flops in each button synchronizer (minimum 2)

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
start_btn  input  1  raw asynchronous start button
stop_btn  input  1  raw asynchronous stop/resume button
limit_in  input  CNT_W  new expiry limit
limit_load  input  1  load limit_in into the limit register on this edge
tmout_in  input  CNT_W  current count from the timer
ctrl  output  2  timer command: 00 hold, 01 clear, 10 count; 11 never driven
running  output  1  high while in RUN
expired  output  1  high while in EXPIRED
done_pulse  output  1  one-cycle pulse on entry to EXPIRED
state_out  output  3  current state encoding, for debug and display

Behaviour:
- One clock (clk). Reset is synchronous and active-high on rst.
- Reset values: state IDLE, ctrl 00, running 0, expired 0, done_pulse 0, state_out IDLE, limit register LIMIT_RESET, all synchronizer and edge flops 0.
- Button path:
  - SYNC_STAGES-flop synchronizer, then a previous-value flop.
  - Edge = synced & ~prev, combinational, exactly one cycle per rising transition.
  - A level held for many cycles gives one edge.
  - A button held through reset gives one edge after rst deasserts.
- Latency: a button first sampled high at edge N changes state, ctrl and status at edge N+SYNC_STAGES (N+2 by default).
- All outputs are registered and decoded from state; done_pulse is registered.
- States and ctrl values:
  - IDLE (000): ctrl 00.
  - CLEAR (001): ctrl 01, lasts exactly one cycle.
  - RUN (010): ctrl 10.
  - PAUSE (011): ctrl 00.
  - EXPIRED (100): ctrl 00.
- Transitions, in priority order within each state:
  - IDLE: start edge -> CLEAR; stop edge ignored.
  - CLEAR: -> RUN unconditionally. Button edges in this cycle are dropped.
  - RUN: hit -> EXPIRED; else start edge -> CLEAR; else stop edge -> PAUSE.
  - PAUSE: start edge -> CLEAR; else stop edge -> RUN (resume, no clear).
  - EXPIRED: start edge -> CLEAR; else stop edge -> IDLE.
- Hit condition: hit = (limit_reg != 0) && (tmout_in >= limit_reg), unsigned compare.
  - limit_reg == 0 means free-run: no expiry, and tmout wraps 15 -> 0 in the timer.
- Start and stop edges in the same cycle: start wins, except in RUN where a hit wins.
- done_pulse is 1 for exactly the first cycle of EXPIRED.
- Limit register:
  - limit_load loads limit_in in any state; the new value is used from the next edge.
  - Loading a limit <= tmout_in while in RUN expires on the following edge.
  - limit_load during rst is ignored; reset wins.
- Counter lag: ctrl stays 10 for the one cycle in which the hit is detected. The timer may advance its internal prescaler once more, but tmout does not step again.
- Reset mid-operation: the next edge gives IDLE and ctrl 00. The timer keeps its stale count until the next CLEAR.
- state_out equals the state encoding.

Decomposition:
- Shared package timer_pkg:
  - CTRL_HOLD=2'b00, CTRL_CLEAR=2'b01, CTRL_COUNT=2'b10.
  - State localparams IDLE..EXPIRED (3-bit).
  - Default CNT_W.
- Sub-module btn_edge:
  - Parameter SYNC_STAGES; ports clk, rst, btn_in, edge_out.
  - Instantiated twice, once for start and once for stop.
- FSM, limit register and compare stay in timer_ctrl.

Test Plan:
- Reset, then idle 10 cycles -> ctrl 00, running 0, expired 0, state_out 000. limit_load with limit_in 9 during rst is ignored, limit_reg stays 15.
- start_btn high from edge N -> ctrl 01 after edge N+2 for exactly one cycle, then 10, running 1. Holding the button 20 cycles gives no second CLEAR.
- Load limit 3 in IDLE, start, drive tmout_in 0,1,2,3 -> edge after tmout_in=3: ctrl 00, expired 1, done_pulse 1 for one cycle, state 100. Stop edge then gives IDLE.
- In RUN: stop -> PAUSE, ctrl 00. Stop again -> RUN, ctrl 10, with no 01 cycle in between. Start and stop together in PAUSE -> CLEAR.
- Limit 0, run, sweep tmout_in 0..15 and wrap to 0 -> never EXPIRED. Then load 5 while tmout_in=7 -> EXPIRED on the next edge.
- rst asserted mid-RUN with tmout_in=6 -> IDLE and ctrl 00 on that edge. A following start produces CLEAR (01) before count (10).
